// File: rtl/accum_ctrl.sv
// accum_ctrl: sequencing controller for the board-level accumulator datapath.
//
// Turns raw active-low pushbuttons into one-cycle add/clear commands, runs a
// free-running auto-add mode paced by a tick divider, and predicts overflow from
// the accumulator feedback before each add (optionally suppressing that add).
//
// Ports:
//   CLOCK_50    in   1      single clock
//   reset       in   1      synchronous, active-high
//   key_add_n   in   1      raw pushbutton, active-low: add operand
//   key_clr_n   in   1      raw pushbutton, active-low: clear accumulator
//   mode_auto   in   1      level: 0 manual, 1 auto-add (asynchronous)
//   sw_operand  in   OP_W   operand switches (asynchronous)
//   acc_sum     in   ACC_W  current accumulator value (feedback)
//   acc_en      out  1      1-cycle pulse: accumulator adds acc_operand
//   acc_clr     out  1      1-cycle pulse: accumulator clears to 0
//   acc_operand out  OP_W   registered operand, valid while acc_en is high
//   op_count    out  CNT_W  count of issued adds, wraps modulo 2^CNT_W
//   ovf_flag    out  1      sticky overflow indicator
//   busy        out  1      high whenever the FSM is not idle
//
// Build option: define ACCUM_CTRL_DEBOUNCE_EN to insert a DB_CYCLES stable-time
// debouncer on both synchronized keys. Left undefined, press events come
// straight from the synchronizers and DB_CYCLES is unused.

`timescale 1ns/1ps

module accum_ctrl #(
    parameter int unsigned OP_W      = 8,
    parameter int unsigned ACC_W     = 10,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             key_add_n,
    input  logic             key_clr_n,
    input  logic             mode_auto,
    input  logic [OP_W-1:0]  sw_operand,
    input  logic [ACC_W-1:0] acc_sum,
    output logic             acc_en,
    output logic             acc_clr,
    output logic [OP_W-1:0]  acc_operand,
    output logic [CNT_W-1:0] op_count,
    output logic             ovf_flag,
    output logic             busy
);

    localparam int unsigned TickW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickReload = TickW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StAuto, StClear} state_e;

    // ------------------------------------------------------------------
    // Input synchronizers. Bit 0 = add key, bit 1 = clear key.
    // ------------------------------------------------------------------
    logic [1:0]      key_s1_q, key_s2_q;
    logic            mode_s1_q, mode_s2_q;
    logic [OP_W-1:0] op_s1_q, op_s2_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1_q  <= 2'b11;
            key_s2_q  <= 2'b11;
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            op_s1_q   <= '0;
            op_s2_q   <= '0;
        end else begin
            key_s1_q  <= {key_clr_n, key_add_n};
            key_s2_q  <= key_s1_q;
            mode_s1_q <= mode_auto;
            mode_s2_q <= mode_s1_q;
            op_s1_q   <= sw_operand;
            op_s2_q   <= op_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Key level feeding the edge detector (optionally debounced).
    // ------------------------------------------------------------------
    logic [1:0] key_lvl;

`ifdef ACCUM_CTRL_DEBOUNCE_EN
    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]     db_q;
    logic [DbW-1:0] db_cnt_q [2];

    // The debounced level follows the synchronized key only after the key has
    // disagreed with it for DB_CYCLES consecutive cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            db_q        <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_s2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                    db_q[i]     <= key_s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign key_lvl = db_q;
`else
    // Keeps the parameter referenced when the debouncer is not built.
    logic unused_db_cycles;
    assign unused_db_cycles = ^DB_CYCLES;
    assign key_lvl = key_s2_q;
`endif

    // ------------------------------------------------------------------
    // Press events: registered 1->0 transition of the key level.
    // ------------------------------------------------------------------
    logic [1:0] lvl_prev_q;
    logic       add_ev_q, clr_ev_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lvl_prev_q <= 2'b11;
            add_ev_q   <= 1'b0;
            clr_ev_q   <= 1'b0;
        end else begin
            lvl_prev_q <= key_lvl;
            add_ev_q   <= lvl_prev_q[0] & ~key_lvl[0];
            clr_ev_q   <= lvl_prev_q[1] & ~key_lvl[1];
        end
    end

    // ------------------------------------------------------------------
    // Overflow prediction on the operand about to be issued.
    // ------------------------------------------------------------------
    logic [ACC_W:0] sum_pred;
    logic           ovf_pred;
    logic           issue_en;

    assign sum_pred = {1'b0, acc_sum} + (ACC_W + 1)'(op_s2_q);
    assign ovf_pred = sum_pred[ACC_W];
    assign issue_en = !((SATURATE != 0) && ovf_pred);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. acc_en/acc_clr and the status
    // registers are updated on the transition into ISSUE/CLEAR so that the
    // pulses coincide with the cycle spent in those states.
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [TickW-1:0] tick_q;
    logic             clr_pend_q;
    logic             acc_en_q, acc_clr_q, ovf_q;
    logic [OP_W-1:0]  acc_operand_q;
    logic [CNT_W-1:0] op_count_q;
    logic             clr_req;

    // A clear that arrived while in ISSUE is served from the next IDLE/AUTO cycle.
    assign clr_req = clr_ev_q | clr_pend_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= StIdle;
            tick_q        <= TickReload;
            clr_pend_q    <= 1'b0;
            acc_en_q      <= 1'b0;
            acc_clr_q     <= 1'b0;
            ovf_q         <= 1'b0;
            acc_operand_q <= '0;
            op_count_q    <= '0;
        end else begin
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            unique case (state_q)
                StIdle, StAuto: begin
                    if (clr_req) begin
                        state_q    <= StClear;
                        acc_clr_q  <= 1'b1;
                        op_count_q <= '0;
                        ovf_q      <= 1'b0;
                        clr_pend_q <= 1'b0;
                    end else if ((state_q == StIdle) && !(add_ev_q && !mode_s2_q)) begin
                        if (mode_s2_q) begin
                            state_q <= StAuto;
                            tick_q  <= TickReload;
                        end
                    end else if ((state_q == StAuto) && !mode_s2_q) begin
                        state_q <= StIdle;
                    end else if ((state_q == StAuto) && (tick_q != '0)) begin
                        tick_q <= tick_q - 1'b1;
                    end else begin
                        // Manual add from IDLE, or tick expiry in AUTO.
                        state_q       <= StIssue;
                        tick_q        <= TickReload;
                        acc_operand_q <= op_s2_q;
                        acc_en_q      <= issue_en;
                        if (issue_en) begin
                            op_count_q <= op_count_q + 1'b1;
                        end
                        if (ovf_pred) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (clr_ev_q) begin
                        clr_pend_q <= 1'b1;
                    end
                    state_q <= mode_s2_q ? StAuto : StIdle;
                end
                StClear: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign acc_en      = acc_en_q;
    assign acc_clr     = acc_clr_q;
    assign acc_operand = acc_operand_q;
    assign op_count    = op_count_q;
    assign ovf_flag    = ovf_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_accum_ctrl.sv
// Self-checking bench for accum_ctrl: a table of manual adds (checked on a
// wrapping and a saturating instance), plus hand-written multi-cycle sequences
// for auto mode, clear priority, pending clear, reset abort and count wrap.

`timescale 1ns/1ps

module tb_accum_ctrl;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned ACC_W     = 10;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned DB_CYCLES = 3;
`ifdef ACCUM_CTRL_DEBOUNCE_EN
    localparam int LAT = 4 + DB_CYCLES;
`else
    localparam int LAT = 4;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             key_add_n, key_clr_n, mode_auto;
    logic [OP_W-1:0]  sw;
    logic [ACC_W-1:0] acc_sum;

    logic             acc_en, acc_clr, ovf_flag, busy;
    logic [OP_W-1:0]  acc_operand;
    logic [CNT_W-1:0] op_count;
    logic             acc_en_s, acc_clr_s, ovf_flag_s, busy_s;
    logic [OP_W-1:0]  acc_operand_s;
    logic [CNT_W-1:0] op_count_s;

    always #10 clk = ~clk;

    accum_ctrl #(
        .OP_W(OP_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV),
        .SATURATE(0), .DB_CYCLES(DB_CYCLES)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .key_add_n(key_add_n), .key_clr_n(key_clr_n),
        .mode_auto(mode_auto), .sw_operand(sw), .acc_sum(acc_sum),
        .acc_en(acc_en), .acc_clr(acc_clr), .acc_operand(acc_operand),
        .op_count(op_count), .ovf_flag(ovf_flag), .busy(busy)
    );

    accum_ctrl #(
        .OP_W(OP_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV),
        .SATURATE(1), .DB_CYCLES(DB_CYCLES)
    ) dut_sat (
        .CLOCK_50(clk), .reset(reset), .key_add_n(key_add_n), .key_clr_n(key_clr_n),
        .mode_auto(mode_auto), .sw_operand(sw), .acc_sum(acc_sum),
        .acc_en(acc_en_s), .acc_clr(acc_clr_s), .acc_operand(acc_operand_s),
        .op_count(op_count_s), .ovf_flag(ovf_flag_s), .busy(busy_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc, en_cnt, en_s_cnt, clr_cnt, busy_low_cnt;
    int first_en_cyc, last_en_cyc, first_clr_cyc;
    int en_op;

    typedef struct {
        logic [OP_W-1:0]  sw;
        logic [ACC_W-1:0] sum;
        int               ovf;
        int               sat_en;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        cyc           = 0;
        en_cnt        = 0;
        en_s_cnt      = 0;
        clr_cnt       = 0;
        busy_low_cnt  = 0;
        first_en_cyc  = -1;
        last_en_cyc   = -1;
        first_clr_cyc = -1;
        en_op         = -1;
    endtask

    // Advance n cycles; outputs are sampled on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc_en) begin
                en_cnt++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                en_op = int'(acc_operand);
            end
            if (acc_en_s) en_s_cnt++;
            if (acc_clr) begin
                clr_cnt++;
                if (first_clr_cyc < 0) first_clr_cyc = cyc;
            end
            if (!busy) busy_low_cnt++;
        end
    endtask

    task automatic press_clr();
        key_clr_n = 1'b0;
        step(10);
        key_clr_n = 1'b1;
        step(12);
    endtask

    task automatic press_add();
        key_add_n = 1'b0;
        step(10);
        key_add_n = 1'b1;
        step(12);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd5,   10'd0,    0, 1};
        vecs[1] = '{8'd10,  10'd1020, 1, 0};
        vecs[2] = '{8'd255, 10'd768,  0, 1};  // sum lands exactly on 1023
        vecs[3] = '{8'd255, 10'd769,  1, 0};
        vecs[4] = '{8'd0,   10'd1023, 0, 1};
        vecs[5] = '{8'd1,   10'd1023, 1, 0};
        vecs[6] = '{8'd170, 10'd100,  0, 1};

        reset     = 1'b1;
        key_add_n = 1'b1;
        key_clr_n = 1'b1;
        mode_auto = 1'b0;
        sw        = '0;
        acc_sum   = '0;
        clear_stats();
        step(3);
        check("rst_acc_en", int'(acc_en), 0);
        check("rst_acc_clr", int'(acc_clr), 0);
        check("rst_operand", int'(acc_operand), 0);
        check("rst_op_count", int'(op_count), 0);
        check("rst_ovf", int'(ovf_flag), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        clear_stats();
        step(6);
        check("idle_no_pulse", en_cnt + clr_cnt, 0);
        check("idle_busy_low", busy_low_cnt, 6);

        // Manual adds from the table, each from a freshly cleared state.
        for (int v = 0; v < 7; v++) begin
            sw      = vecs[v].sw;
            acc_sum = vecs[v].sum;
            press_clr();
            clear_stats();
            press_add();
            check($sformatf("v%0d_en_cnt", v), en_cnt, 1);
            check($sformatf("v%0d_latency", v), first_en_cyc, LAT);
            check($sformatf("v%0d_operand", v), en_op, int'(vecs[v].sw));
            check($sformatf("v%0d_ovf", v), int'(ovf_flag), vecs[v].ovf);
            check($sformatf("v%0d_ovf_sat", v), int'(ovf_flag_s), vecs[v].ovf);
            check($sformatf("v%0d_count", v), int'(op_count), 1);
            check($sformatf("v%0d_en_sat", v), en_s_cnt, vecs[v].sat_en);
            check($sformatf("v%0d_count_sat", v), int'(op_count_s), vecs[v].sat_en);
        end

        // Auto mode for 20 cycles: pulses at 7,12,17,22, the last one completing
        // while mode_auto is already falling.
        sw      = 8'd3;
        acc_sum = '0;
        press_clr();
        clear_stats();
        mode_auto = 1'b1;
        step(20);
        mode_auto = 1'b0;
        check("auto_busy_low", busy_low_cnt, 2);
        step(10);
        check("auto_pulses", en_cnt, 4);
        check("auto_first", first_en_cyc, 7);
        check("auto_last", last_en_cyc, 22);
        check("auto_count", int'(op_count), 4);
        check("auto_operand", en_op, 3);
        check("auto_idle_after", int'(busy), 0);

        // Simultaneous add and clear after an overflowing add.
        sw      = 8'd10;
        acc_sum = 10'd1020;
        press_add();
        check("pre_sim_count", int'(op_count), 5);
        check("pre_sim_ovf", int'(ovf_flag), 1);
        clear_stats();
        key_add_n = 1'b0;
        key_clr_n = 1'b0;
        step(10);
        key_add_n = 1'b1;
        key_clr_n = 1'b1;
        step(12);
        check("sim_clr_cnt", clr_cnt, 1);
        check("sim_clr_latency", first_clr_cyc, LAT);
        check("sim_en_cnt", en_cnt, 0);
        check("sim_count", int'(op_count), 0);
        check("sim_ovf", int'(ovf_flag), 0);

        // Clear event landing on the ISSUE cycle is held and served afterwards.
        sw      = 8'd9;
        acc_sum = '0;
        clear_stats();
        key_add_n = 1'b0;
        step(1);
        key_clr_n = 1'b0;
        step(10);
        key_add_n = 1'b1;
        key_clr_n = 1'b1;
        step(12);
        check("pend_en_cnt", en_cnt, 1);
        check("pend_en_at", first_en_cyc, LAT);
        check("pend_clr_cnt", clr_cnt, 1);
        check("pend_clr_at", first_clr_cyc, LAT + 2);
        check("pend_count", int'(op_count), 0);

        // Reset on the edge that would enter ISSUE aborts the add.
        sw = 8'd7;
        press_add();
        check("pre_rst_count", int'(op_count), 1);
        clear_stats();
        key_add_n = 1'b0;
        step(LAT - 1);
        reset     = 1'b1;
        key_add_n = 1'b1;
        step(1);
        check("abort_acc_en", int'(acc_en), 0);
        check("abort_operand", int'(acc_operand), 0);
        check("abort_count", int'(op_count), 0);
        check("abort_ovf", int'(ovf_flag), 0);
        check("abort_busy", int'(busy), 0);
        reset = 1'b0;
        step(12);
        check("abort_no_pulse", en_cnt, 0);
        check("abort_idle", int'(busy), 0);

        // op_count wraps 255 -> 0 under auto mode.
        sw      = '0;
        acc_sum = '0;
        press_clr();
        clear_stats();
        mode_auto = 1'b1;
        for (int i = 0; i < 2000 && en_cnt < 256; i++) begin
            step(1);
            if (en_cnt == 255 && acc_en) check("wrap_count_255", int'(op_count), 255);
        end
        check("wrap_pulses", en_cnt, 256);
        check("wrap_count_0", int'(op_count), 0);
        check("wrap_no_ovf", int'(ovf_flag), 0);
        mode_auto = 1'b0;
        step(12);

`ifdef ACCUM_CTRL_DEBOUNCE_EN
        // Single-cycle bounces are filtered; the final steady press gives one add.
        sw = 8'd4;
        press_clr();
        clear_stats();
        for (int b = 0; b < 3; b++) begin
            key_add_n = 1'b0;
            step(1);
            key_add_n = 1'b1;
            step(1);
        end
        step(6);
        check("bounce_no_event", en_cnt, 0);
        clear_stats();
        press_add();
        check("bounce_en_cnt", en_cnt, 1);
        check("bounce_latency", first_en_cyc, LAT);
        check("bounce_count", int'(op_count), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
